// File: rtl/data_memory_if.sv
// Bus between the ALU/register-file side and the data memory stage.
// The master drives the access request; the slave returns load data, status and counters.
interface data_memory_if;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [63:0] read_data;
  logic        busy;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] load_count;
  logic [31:0] store_count;

  modport master (
    output addr, write_data, mem_read, mem_write, size, unsigned_ld,
    input  read_data, busy, misaligned, out_of_range, load_count, store_count
  );

  modport slave (
    input  addr, write_data, mem_read, mem_write, size, unsigned_ld,
    output read_data, busy, misaligned, out_of_range, load_count, store_count
  );
endinterface

// File: rtl/data_memory.sv
// Little-endian 64-bit data memory with post-reset clear sweep and access-fault flags.
// Define DMEM_PERF_EN to build the saturating load/store counters.
module data_memory #(
  parameter int unsigned DEPTH = 256
) (
  input logic         clk,
  input logic         rst_n,
  data_memory_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [63:0] MemBytes = 64'(DEPTH) << 3;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [63:0]      mem_q [DEPTH];

  logic             busy, req, oor, mis, access_ok;
  logic [IDX_W-1:0] idx;
  logic [2:0]       off;
  logic [63:0]      rd_word, rd_shift, ld_val, wr_shift, merged;
  logic [7:0]       lane_mask, byte_en;
  logic             sx;
  logic             wr_en, store_commit;
  logic [IDX_W-1:0] wr_idx;
  logic [63:0]      wr_word;

  // Sweep sequencing
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == StClear) begin
      clr_idx_d = clr_idx_q + IDX_W'(1);
      if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d = StReady;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Address decode and fault flags; all forced low while the sweep runs
  always_comb begin
    busy = (state_q == StClear);
    req  = bus.mem_read | bus.mem_write;
    idx  = bus.addr[IDX_W+2:3];
    off  = bus.addr[2:0];
    oor  = !busy && req && (bus.addr >= MemBytes);
    case (bus.size)
      2'b01:   mis = off[0];
      2'b10:   mis = (off[1:0] != 2'b00);
      2'b11:   mis = (off != 3'b000);
      default: mis = 1'b0;
    endcase
    mis       = !busy && req && !oor && mis;
    access_ok = !busy && !oor && !mis;
  end

  // Load path: shift the addressed lane down, then extend
  always_comb begin
    rd_word  = mem_q[idx];
    rd_shift = rd_word >> {off, 3'b000};
    sx       = !bus.unsigned_ld;
    case (bus.size)
      2'b00:   ld_val = {{56{sx & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   ld_val = {{48{sx & rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   ld_val = {{32{sx & rd_shift[31]}}, rd_shift[31:0]};
      default: ld_val = rd_shift;
    endcase
  end

  // Store path: byte-lane merge into the current word
  always_comb begin
    case (bus.size)
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      2'b10:   lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
    byte_en  = lane_mask << off;
    wr_shift = bus.write_data << {off, 3'b000};
    for (int i = 0; i < 8; i++) begin
      merged[i*8 +: 8] = byte_en[i] ? wr_shift[i*8 +: 8] : rd_word[i*8 +: 8];
    end
  end

  // Single write port shared by the sweep and committed stores; reset blocks both
  always_comb begin
    store_commit = rst_n && !busy && bus.mem_write && access_ok;
    wr_en        = 1'b0;
    wr_idx       = idx;
    wr_word      = merged;
    if (busy) begin
      wr_en   = rst_n;
      wr_idx  = clr_idx_q;
      wr_word = '0;
    end else if (store_commit) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

  assign bus.read_data    = (bus.mem_read && access_ok) ? ld_val : 64'd0;
  assign bus.busy         = busy;
  assign bus.misaligned   = mis;
  assign bus.out_of_range = oor;

`ifdef DMEM_PERF_EN
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (bus.mem_read && access_ok && (load_cnt_q != 32'hFFFF_FFFF)) begin
      load_cnt_d = load_cnt_q + 32'd1;
    end
    if (store_commit && (store_cnt_q != 32'hFFFF_FFFF)) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign bus.load_count  = load_cnt_q;
  assign bus.store_count = store_cnt_q;
`else
  assign bus.load_count  = 32'd0;
  assign bus.store_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Randomized and directed bench for data_memory against a byte-array reference model.
module tb_data_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NBYTES = DEPTH * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem_b [NBYTES];

  data_memory_if bus ();

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit m_oor(input logic [63:0] a);
    return a >= 64'(NBYTES);
  endfunction

  function automatic bit m_mis(input logic [63:0] a, input logic [1:0] sz);
    int nb = 1 << sz;
    return !m_oor(a) && ((a % 64'(nb)) != 0);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input logic [1:0] sz,
                                         input bit uns);
    int nb = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v = v | (64'(mem_b[int'(a) + i]) << (8 * i));
    if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
    return v;
  endfunction

  function automatic void m_store(input logic [63:0] a, input logic [1:0] sz,
                                  input logic [63:0] d);
    int nb = 1 << sz;
    if (m_oor(a) || m_mis(a, sz)) return;
    for (int i = 0; i < nb; i++) mem_b[int'(a) + i] = 8'(d >> (8 * i));
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < int'(NBYTES); i++) mem_b[i] = 8'h00;
  endfunction

  task automatic idle();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.addr = '0;
    bus.size = 2'b00; bus.unsigned_ld = 1'b0; bus.write_data = '0;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [63:0] a,
                       input logic [1:0] sz, input bit uns, input logic [63:0] wd);
    bus.mem_read = rd; bus.mem_write = wr; bus.addr = a;
    bus.size = sz; bus.unsigned_ld = uns; bus.write_data = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    bit done = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b want 1", bus.busy);
    end
    rst_n = 1'b1;
    while (!done && n < 1000) begin
      if (n == 10) begin
        drive(1, 1, 64'h0, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++;
        if (bus.read_data !== 64'd0) begin
          errors++; $display("FAIL busy_read_data: got %h want 0", bus.read_data);
        end
      end else if (n == 11) begin
        drive(1, 1, 64'h803, 2'b01, 0, 64'h1234);
        checks++;
        if (bus.out_of_range !== 1'b0 || bus.misaligned !== 1'b0) begin
          errors++;
          $display("FAIL busy_flags: got oor=%b mis=%b want 0 0", bus.out_of_range,
                   bus.misaligned);
        end
      end
      tick();
      n++;
      if (!bus.busy) done = 1;
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL busy_cycles: got %0d want 256", n);
    end
    m_clear();
    drive(1, 0, 64'h7F8, 2'b11, 0, '0);
    checks++;
    if (bus.read_data !== 64'd0) begin
      errors++; $display("FAIL sweep_top: got %h want 0", bus.read_data);
    end
    drive(1, 0, 64'h0, 2'b11, 0, '0);
    checks++;
    if (bus.read_data !== 64'd0) begin
      errors++; $display("FAIL busy_store_ignored: got %h want 0", bus.read_data);
    end
    tick();
  endtask

  task automatic test_byte_lane();
    drive(0, 1, 64'h10, 2'b11, 0, 64'h1122_3344_5566_7788); tick();
    m_store(64'h10, 2'b11, 64'h1122_3344_5566_7788);
    drive(0, 1, 64'h13, 2'b00, 0, 64'hAAAA_AAAA_AAAA_AAF0); tick();
    m_store(64'h13, 2'b00, 64'hAAAA_AAAA_AAAA_AAF0);
    drive(1, 0, 64'h10, 2'b11, 0, '0);
    checks++;
    if (bus.read_data !== 64'h1122_3344_F066_7788) begin
      errors++; $display("FAIL lane_double: got %h want 11223344f0667788", bus.read_data);
    end
    drive(1, 0, 64'h13, 2'b00, 0, '0);
    checks++;
    if (bus.read_data !== 64'hFFFF_FFFF_FFFF_FFF0) begin
      errors++; $display("FAIL byte_signed: got %h want fffffffffffffff0", bus.read_data);
    end
    drive(1, 0, 64'h13, 2'b00, 1, '0);
    checks++;
    if (bus.read_data !== 64'h0000_0000_0000_00F0) begin
      errors++; $display("FAIL byte_unsigned: got %h want f0", bus.read_data);
    end
    drive(1, 0, 64'h12, 2'b01, 0, '0);
    checks++;
    if (bus.read_data !== m_load(64'h12, 2'b01, 0)) begin
      errors++;
      $display("FAIL half_signed: got %h want %h", bus.read_data, m_load(64'h12, 2'b01, 0));
    end
    drive(1, 0, 64'h14, 2'b10, 1, '0);
    checks++;
    if (bus.read_data !== m_load(64'h14, 2'b10, 1)) begin
      errors++;
      $display("FAIL word_unsigned: got %h want %h", bus.read_data, m_load(64'h14, 2'b10, 1));
    end
    tick();
  endtask

  task automatic test_misaligned();
    logic [63:0] addrs [3] = '{64'h21, 64'h22, 64'h24};
    logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
    drive(0, 1, 64'h20, 2'b11, 0, 64'hA5A5_A5A5_A5A5_A5A5); tick();
    m_store(64'h20, 2'b11, 64'hA5A5_A5A5_A5A5_A5A5);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, addrs[i], sizes[i], 0, 64'h0123_4567_89AB_CDEF);
      checks++;
      if (bus.misaligned !== 1'b1 || bus.out_of_range !== 1'b0 || bus.read_data !== 64'd0) begin
        errors++;
        $display("FAIL misaligned_%0d: got mis=%b oor=%b rd=%h want 1 0 0", i,
                 bus.misaligned, bus.out_of_range, bus.read_data);
      end
      tick();
    end
    drive(1, 0, 64'h20, 2'b11, 0, '0);
    checks++;
    if (bus.read_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      errors++; $display("FAIL misaligned_unchanged: got %h want a5a5a5a5a5a5a5a5",
                         bus.read_data);
    end
    drive(1, 0, 64'h22, 2'b01, 0, '0);
    checks++;
    if (bus.misaligned !== 1'b0 || bus.read_data !== m_load(64'h22, 2'b01, 0)) begin
      errors++;
      $display("FAIL half_aligned: got mis=%b rd=%h want 0 %h", bus.misaligned,
               bus.read_data, m_load(64'h22, 2'b01, 0));
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [63:0] addrs [2] = '{64'h800, 64'h8000_0000_0000_0010};
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, addrs[i], 2'b11, 0, 64'hDEAD_BEEF_DEAD_BEEF);
      checks++;
      if (bus.out_of_range !== 1'b1 || bus.misaligned !== 1'b0) begin
        errors++;
        $display("FAIL oor_store_%0d: got oor=%b mis=%b want 1 0", i, bus.out_of_range,
                 bus.misaligned);
      end
      tick();
      drive(1, 0, addrs[i], 2'b11, 0, '0);
      checks++;
      if (bus.out_of_range !== 1'b1 || bus.read_data !== 64'd0) begin
        errors++;
        $display("FAIL oor_load_%0d: got oor=%b rd=%h want 1 0", i, bus.out_of_range,
                 bus.read_data);
      end
      tick();
    end
    drive(1, 0, 64'h0, 2'b11, 0, '0);
    checks++;
    if (bus.read_data !== m_load(64'h0, 2'b11, 0)) begin
      errors++; $display("FAIL oor_alias_idx0: got %h want %h", bus.read_data,
                         m_load(64'h0, 2'b11, 0));
    end
    drive(1, 0, 64'h10, 2'b11, 0, '0);
    checks++;
    if (bus.read_data !== 64'h1122_3344_F066_7788) begin
      errors++; $display("FAIL oor_alias_idx2: got %h want 11223344f0667788", bus.read_data);
    end
    tick();
  endtask

  task automatic test_rw_same_cycle();
    drive(0, 1, 64'h40, 2'b11, 0, 64'd5); tick();
    m_store(64'h40, 2'b11, 64'd5);
    drive(1, 1, 64'h40, 2'b11, 0, 64'd9);
    checks++;
    if (bus.read_data !== 64'd5) begin
      errors++; $display("FAIL rw_old_value: got %h want 5", bus.read_data);
    end
    tick();
    m_store(64'h40, 2'b11, 64'd9);
    drive(1, 0, 64'h40, 2'b11, 0, '0);
    checks++;
    if (bus.read_data !== 64'd9) begin
      errors++; $display("FAIL rw_new_value: got %h want 9", bus.read_data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [63:0] a;
      logic [63:0] wd = {$urandom(), $urandom()};
      bit rd = 1'($urandom());
      bit wr = 1'($urandom());
      bit uns = 1'($urandom());
      bit e_oor, e_mis;
      logic [63:0] e_rd;
      int pick = $urandom_range(0, 9);
      if (pick < 8) begin
        a = 64'($urandom_range(0, NBYTES - 1));
        if (pick < 6) a = a & ~64'((1 << sz) - 1);
      end else if (pick == 8) begin
        a = 64'(NBYTES) + 64'($urandom_range(0, 4095));
      end else begin
        a = {$urandom(), 32'($urandom_range(0, NBYTES - 1))} | 64'h0000_0001_0000_0000;
      end
      drive(rd, wr, a, sz, uns, wd);
      e_oor = (rd || wr) && m_oor(a);
      e_mis = (rd || wr) && m_mis(a, sz);
      e_rd  = (rd && !e_oor && !e_mis) ? m_load(a, sz, uns) : 64'd0;
      checks++;
      if (bus.out_of_range !== e_oor || bus.misaligned !== e_mis || bus.read_data !== e_rd) begin
        errors++;
        $display("FAIL random_%0d a=%h sz=%0d: got oor=%b mis=%b rd=%h want %b %b %h", n, a,
                 sz, bus.out_of_range, bus.misaligned, bus.read_data, e_oor, e_mis, e_rd);
      end
      tick();
      if (wr) m_store(a, sz, wd);
    end
  endtask

  task automatic test_mid_sweep_reset();
    int n = 0;
    bit done = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL sweep_cycle100_busy: got %b want 1", bus.busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    while (!done && n < 1000) begin
      tick();
      n++;
      if (!bus.busy) done = 1;
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL restart_busy_cycles: got %0d want 256", n);
    end
    m_clear();
  endtask

  task automatic test_counters();
    logic [63:0] la [3] = '{64'h10, 64'h40, 64'h7FF};
    logic [1:0]  ls [3] = '{2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, la[i], ls[i], 0, '0);
      checks++;
      if (bus.read_data !== m_load(la[i], ls[i], 0)) begin
        errors++; $display("FAIL post_sweep_load_%0d: got %h want %h", i, bus.read_data,
                           m_load(la[i], ls[i], 0));
      end
      tick();
    end
    drive(1, 0, 64'h3, 2'b01, 0, '0);
    checks++;
    if (bus.misaligned !== 1'b1) begin
      errors++; $display("FAIL cnt_misaligned: got %b want 1", bus.misaligned);
    end
    tick();
    drive(0, 1, 64'h18, 2'b11, 0, 64'h77); tick();
    drive(0, 1, 64'h1C, 2'b10, 0, 64'h66); tick();
`ifdef DMEM_PERF_EN
    checks++;
    if (bus.load_count !== 32'd3 || bus.store_count !== 32'd2) begin
      errors++; $display("FAIL counters: got loads=%0d stores=%0d want 3 2", bus.load_count,
                         bus.store_count);
    end
`else
    checks++;
    if (bus.load_count !== 32'd0 || bus.store_count !== 32'd0) begin
      errors++; $display("FAIL counters_tied: got loads=%0d stores=%0d want 0 0",
                         bus.load_count, bus.store_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_lane();
    test_misaligned();
    test_out_of_range();
    test_rw_same_cycle();
    test_random();
    test_mid_sweep_reset();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
